// File: rtl/jenc_pkg.sv
// Shared types for the JPEG entropy path: coefficient, chroma tag,
// sequencer states and the sideband carried alongside each pair.
package jenc_pkg;

    typedef logic signed [10:0] coef_t;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } chroma_t;

    localparam int PAIRS_PER_BLOCK = 32;
    localparam int BLOCKS_PER_MCU  = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BANK,
        S_ISSUE,
        S_DRAIN
    } seq_state_t;

    typedef struct packed {
        logic       bank;
        logic [4:0] cnt;
        chroma_t    chroma;
        logic       last_mcu;
    } side_t;

    typedef struct packed {
        side_t       side;
        coef_t [1:0] data;
    } pair_ent_t;

endpackage

// File: rtl/jenc_skid_fifo.sv
// Small synchronous FIFO with occupancy count; the head entry is
// visible combinationally from registered state.
module jenc_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    push_into_full: assert property (
        @(posedge clk) disable iff (!resetn) !(push && full)
    );

endmodule

// File: rtl/entropy_mcu_sequencer.sv
// Reads ping-pong MCU coefficient banks and feeds zig-zag pairs with
// block/chroma/last-MCU sideband to the entropy encoder.
module entropy_mcu_sequencer
    import jenc_pkg::*;
#(
    parameter int Y_BLOCKS       = 4,
    parameter int BLOCKS_PER_MCU = 6,
    parameter int MCU_CNT_W      = 16,
    parameter int FIFO_DEPTH     = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [MCU_CNT_W-1:0] num_mcus,
    output logic                 busy,
    output logic                 done,
    input  logic [1:0]           bank_full,
    output logic [1:0]           bank_release,
    output logic                 rd_en,
    output logic                 rd_bank,
    output logic [7:0]           rd_addr,
    input  coef_t [1:0]          rd_data,
    output coef_t [1:0]          q,
    output logic                 q_valid,
    input  logic                 q_hold,
    output logic [4:0]           q_cnt,
    output logic [1:0]           q_chroma,
    output logic                 q_last_mcu
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [4:0] LAST_PAIR = 5'(PAIRS_PER_BLOCK - 1);
    localparam logic [2:0] LAST_BLK  = 3'(BLOCKS_PER_MCU - 1);

    seq_state_t           state, state_n;
    logic                 ptr, ptr_n;
    logic [2:0]           block, block_n;
    logic [4:0]           pair, pair_n;
    logic [MCU_CNT_W-1:0] remain, remain_n;
    logic                 zero_done, zero_done_n;
    logic                 inflight;
    logic                 room;
    logic                 pop;
    logic                 last_mcu;
    logic [1:0]           release_n;
    logic [CW-1:0]        fifo_count;
    side_t                side_now, side_d;
    pair_ent_t            head, wr_ent;

    function automatic chroma_t chroma_of(input logic [2:0] blk);
        if (blk < 3'(Y_BLOCKS))  return CH_Y;
        if (blk == 3'(Y_BLOCKS)) return CH_CB;
        return CH_CR;
    endfunction

    // Occupancy counts the read in flight so the FIFO can never overflow.
    assign room = (OW'(fifo_count) + OW'(inflight)) <= OW'(FIFO_DEPTH - 1);
    assign last_mcu = (remain == MCU_CNT_W'(1));

    assign side_now.bank     = ptr;
    assign side_now.cnt      = pair;
    assign side_now.chroma   = chroma_of(block);
    assign side_now.last_mcu = last_mcu;

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        block_n     = block;
        pair_n      = pair;
        remain_n    = remain;
        zero_done_n = 1'b0;
        rd_en       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_mcus != '0) begin
                        remain_n = num_mcus;
                        ptr_n    = 1'b0;
                        block_n  = '0;
                        pair_n   = '0;
                        state_n  = S_WAIT_BANK;
                    end else begin
                        zero_done_n = 1'b1;
                    end
                end
            end
            S_WAIT_BANK: begin
                if (bank_full[ptr]) begin
                    block_n = '0;
                    pair_n  = '0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (room) begin
                    rd_en  = 1'b1;
                    pair_n = pair + 1'b1;
                    if (pair == LAST_PAIR) begin
                        block_n = block + 1'b1;
                        if (block == LAST_BLK) begin
                            block_n  = '0;
                            remain_n = remain - 1'b1;
                            ptr_n    = ~ptr;
                            // Skip the wait cycle when the other bank is ready.
                            if (last_mcu)
                                state_n = S_DRAIN;
                            else if (!bank_full[~ptr])
                                state_n = S_WAIT_BANK;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_count == '0 && !inflight) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            ptr          <= 1'b0;
            block        <= '0;
            pair         <= '0;
            remain       <= '0;
            zero_done    <= 1'b0;
            inflight     <= 1'b0;
            side_d       <= '0;
            bank_release <= 2'b00;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            block        <= block_n;
            pair         <= pair_n;
            remain       <= remain_n;
            zero_done    <= zero_done_n;
            inflight     <= rd_en;
            bank_release <= release_n;
            if (rd_en) side_d <= side_now;
        end
    end

    assign wr_ent.side = side_d;
    assign wr_ent.data = rd_data;

    jenc_skid_fifo #(
        .WIDTH ($bits(pair_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight),
        .wdata  (wr_ent),
        .pop    (pop),
        .rdata  (head),
        .count  (fifo_count)
    );

    assign q_valid = (fifo_count != '0);
    assign pop     = q_valid && !q_hold;

    always_comb begin
        release_n = 2'b00;
        if (pop && head.side.chroma == CH_CR && head.side.cnt == LAST_PAIR)
            release_n[head.side.bank] = 1'b1;
    end

    assign q          = q_valid ? head.data : '0;
    assign q_cnt      = q_valid ? head.side.cnt : 5'd0;
    assign q_chroma   = q_valid ? head.side.chroma : 2'd0;
    assign q_last_mcu = q_valid && head.side.last_mcu;

    assign busy = (state != S_IDLE);
    assign done = zero_done
                | (state == S_DRAIN && fifo_count == '0 && !inflight);

    assign rd_bank = ptr;
    assign rd_addr = {block, pair};

endmodule
